// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle two's-complement adder/subtractor.
// Sums CHUNK bits per clock, LSB slice first, over NCHUNK = WIDTH/CHUNK cycles.
// The final result and flags match a full-width combinational add: carry out of the
// MSB, signed overflow (carry into MSB ^ carry out of MSB), and zero.
// Operands arrive on an in_valid/in_ready handshake. Results leave on an
// out_valid/out_ready handshake.

module chunked_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // already inverted for subtract
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   sum_ext;
  logic [WIDTH-1:0] result_merged;
  logic             cin_msb;

  // Select slice k of both operands, add it with the running carry and merge the
  // sum into the result.
  always_comb begin
    a_slice       = '0;
    b_slice       = '0;
    result_merged = result_q;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (k_q == KW'(i)) begin
        a_slice = a_q[i*CHUNK +: CHUNK];
        b_slice = b_q[i*CHUNK +: CHUNK];
      end
    end
    sum_ext = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (k_q == KW'(i)) begin
        result_merged[i*CHUNK +: CHUNK] = sum_ext[CHUNK-1:0];
      end
    end
    // The carry into the top bit is recovered from that bit's sum and its operands.
    // This works for any CHUNK, including CHUNK == 1.
    cin_msb = sum_ext[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1];
  end

  // Next-state logic and datapath update.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    k_d        = k_q;
    result_d   = result_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{subtract}};
          carry_d = subtract;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d = result_merged;
        carry_d  = sum_ext[CHUNK];
        k_d      = k_q + KW'(1);
        if (k_q == KLAST) begin
          carryout_d = sum_ext[CHUNK];
          overflow_d = cin_msb ^ sum_ext[CHUNK];
          zero_d     = (result_merged == '0);
          k_d        = '0;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers. Reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      k_q        <= '0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      k_q        <= k_d;
      result_q   <= result_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub with three instances: 32/8 (directed cases),
// 8/2 and 32/32 (reference-model sweeps).

module tb_chunked_addsub;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 32/8 instance
  logic        m_in_valid, m_in_ready, m_subtract, m_out_valid, m_out_ready;
  logic [31:0] m_a, m_b, m_result;
  logic        m_carryout, m_overflow, m_zero;

  chunked_addsub #(.WIDTH(32), .CHUNK(8)) u_main (
    .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .subtract(m_subtract), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .result(m_result), .carryout(m_carryout),
    .overflow(m_overflow), .zero(m_zero)
  );

  // 8/2 instance
  logic       s_in_valid, s_in_ready, s_subtract, s_out_valid, s_out_ready;
  logic [7:0] s_a, s_b, s_result;
  logic       s_carryout, s_overflow, s_zero;

  chunked_addsub #(.WIDTH(8), .CHUNK(2)) u_small (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .subtract(s_subtract), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .result(s_result), .carryout(s_carryout),
    .overflow(s_overflow), .zero(s_zero)
  );

  // 32/32 instance
  logic        w_in_valid, w_in_ready, w_subtract, w_out_valid, w_out_ready;
  logic [31:0] w_a, w_b, w_result;
  logic        w_carryout, w_overflow, w_zero;

  chunked_addsub #(.WIDTH(32), .CHUNK(32)) u_wide (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .subtract(w_subtract), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .result(w_result), .carryout(w_carryout),
    .overflow(w_overflow), .zero(w_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation into the 32/8 instance and returns the outputs and latency
  // (-1 on timeout).
  task automatic op32(input logic [31:0] ta, input logic [31:0] tb_, input logic tsub,
                      output logic [31:0] r, output logic co, output logic ov,
                      output logic z, output int lat);
    m_in_valid = 1'b1; m_a = ta; m_b = tb_; m_subtract = tsub;
    tick();
    m_in_valid = 1'b0; m_a = $urandom; m_b = $urandom; m_subtract = 1'b0;
    lat = 0;
    while (!m_out_valid && lat < 40) begin tick(); lat++; end
    if (!m_out_valid) lat = -1;
    r = m_result; co = m_carryout; ov = m_overflow; z = m_zero;
    m_out_ready = 1'b1;
    tick();
    m_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", m_in_ready, m_out_valid);
    end
    vectors++;
    if ({m_result, m_carryout, m_overflow, m_zero} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: result=%h co=%b ov=%b z=%b, want all 0",
               m_result, m_carryout, m_overflow, m_zero);
    end
  endtask

  // Checks one directed 32/8 case.
  task automatic test_case32(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                             input logic tsub, input logic [31:0] er, input logic eco,
                             input logic eov, input logic ez);
    logic [31:0] r; logic co, ov, z; int lat;
    op32(ta, tb_, tsub, r, co, ov, z, lat);
    vectors++;
    if (lat !== 4) begin
      miscompares++; $display("FAIL %s latency: got %0d want 4", name, lat);
    end
    vectors++;
    if (r !== er) begin
      miscompares++; $display("FAIL %s result: got %h want %h", name, r, er);
    end
    vectors++;
    if ({co, ov, z} !== {eco, eov, ez}) begin
      miscompares++;
      $display("FAIL %s flags co/ov/z: got %b%b%b want %b%b%b", name, co, ov, z, eco, eov, ez);
    end
  endtask

  task automatic test_add();
    test_case32("add_pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    test_case32("add_neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    test_case32("add_wrap_zero", 32'h0006_1A80, 32'hFFF9_E580, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    test_case32("add_plain", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_subtract();
    test_case32("sub_equal", 32'h5, 32'h5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    test_case32("sub_min_ovf", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    test_case32("sub_borrow", 32'h3, 32'h5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_pressure();
    int waited = 0;
    m_in_valid = 1'b1; m_a = 32'h1234_5678; m_b = 32'h1111_1111; m_subtract = 1'b0;
    tick();
    m_in_valid = 1'b0;
    while (!m_out_valid && waited < 40) begin tick(); waited++; end
    vectors++;
    if (!m_out_valid) begin
      miscompares++; $display("FAIL bp_complete: out_valid=0 after %0d cycles", waited);
    end
    for (int i = 0; i < 5; i++) begin
      m_in_valid = 1'b1; m_a = $urandom; m_b = $urandom; m_subtract = i[0];
      tick();
      vectors++;
      if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_hs[%0d]: out_valid=%b in_ready=%b want 1 0", i, m_out_valid,
                 m_in_ready);
      end
      vectors++;
      if ({m_result, m_carryout, m_overflow, m_zero} !== {32'h2345_6789, 3'b000}) begin
        miscompares++;
        $display("FAIL bp_hold_data[%0d]: result=%h flags=%b%b%b want 23456789 000", i, m_result,
                 m_carryout, m_overflow, m_zero);
      end
    end
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    tick();
    m_out_ready = 1'b0;
    vectors++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_result !== 32'h2345_6789) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b result=%h want 0 1 23456789",
               m_out_valid, m_in_ready, m_result);
    end
    tick();
    vectors++;
    if (m_in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_no_queue: in_ready=%b want 1", m_in_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r; logic co, ov, z; int lat;
    m_in_valid = 1'b1; m_a = 32'hFFFF_FFFF; m_b = 32'h1; m_subtract = 1'b0;
    tick();  // first RUN cycle
    m_in_valid = 1'b0;
    tick();  // second RUN cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_state: out_valid=%b in_ready=%b want 0 1", m_out_valid, m_in_ready);
    end
    vectors++;
    if ({m_result, m_carryout, m_overflow, m_zero} !== 35'h0) begin
      miscompares++;
      $display("FAIL abort_outputs: result=%h flags=%b%b%b want 0 000", m_result, m_carryout,
               m_overflow, m_zero);
    end
    tick(); tick(); tick(); tick();
    vectors++;
    if (m_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL abort_no_valid: out_valid=%b want 0", m_out_valid);
    end
    test_case32("after_abort", 32'h3, 32'hFFFF_FFFF, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_narrow();
    logic [7:0] ta, tb_, bb, er; logic [8:0] full; logic tsub, eov; int lat;
    for (int i = 0; i < 320; i++) begin
      ta = (i < 256) ? 8'(i) : 8'($urandom);
      tb_ = (i % 5 == 0) ? ta : 8'($urandom);
      tsub = ((i & 1) != 0);
      bb = tsub ? ~tb_ : tb_;
      full = {1'b0, ta} + {1'b0, bb} + {8'h0, tsub};
      er = full[7:0];
      eov = (ta[7] == bb[7]) && (er[7] != ta[7]);
      s_in_valid = 1'b1; s_a = ta; s_b = tb_; s_subtract = tsub;
      tick();
      s_in_valid = 1'b0; s_a = 8'($urandom);
      lat = 0;
      while (!s_out_valid && lat < 40) begin tick(); lat++; end
      vectors++;
      if (lat !== 4 || s_result !== er || {s_carryout, s_overflow, s_zero} !==
          {full[8], eov, er == 8'h0}) begin
        miscompares++;
        $display("FAIL narrow %h%s%h: lat=%0d r=%h f=%b%b%b want lat=4 r=%h f=%b%b%b", ta,
                 tsub ? "-" : "+", tb_, lat, s_result, s_carryout, s_overflow, s_zero, er,
                 full[8], eov, er == 8'h0);
      end
      s_out_ready = 1'b1;
      tick();
      s_out_ready = 1'b0;
    end
  endtask

  task automatic test_single_chunk();
    logic [31:0] ta, tb_, bb, er; logic [32:0] full; logic tsub, eov; int lat;
    for (int i = 0; i < 400; i++) begin
      ta = $urandom; tb_ = (i % 7 == 0) ? ta : $urandom;
      if (i == 1) begin ta = 32'h7FFF_FFFF; tb_ = 32'h1; end
      tsub = ($urandom_range(0, 1) == 1);
      bb = tsub ? ~tb_ : tb_;
      full = {1'b0, ta} + {1'b0, bb} + {32'h0, tsub};
      er = full[31:0];
      eov = (ta[31] == bb[31]) && (er[31] != ta[31]);
      w_in_valid = 1'b1; w_a = ta; w_b = tb_; w_subtract = tsub;
      tick();
      w_in_valid = 1'b0; w_a = $urandom;
      lat = 0;
      while (!w_out_valid && lat < 40) begin tick(); lat++; end
      vectors++;
      if (lat !== 1 || w_result !== er || {w_carryout, w_overflow, w_zero} !==
          {full[32], eov, er == 32'h0}) begin
        miscompares++;
        $display("FAIL single %h%s%h: lat=%0d r=%h f=%b%b%b want lat=1 r=%h f=%b%b%b", ta,
                 tsub ? "-" : "+", tb_, lat, w_result, w_carryout, w_overflow, w_zero, er,
                 full[32], eov, er == 32'h0);
      end
      w_out_ready = 1'b1;
      tick();
      w_out_ready = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    m_in_valid = 1'b0; m_a = '0; m_b = '0; m_subtract = 1'b0; m_out_ready = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_subtract = 1'b0; s_out_ready = 1'b0;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_subtract = 1'b0; w_out_ready = 1'b0;
    test_reset();
    test_add();
    test_subtract();
    test_back_pressure();
    test_reset_abort();
    test_narrow();
    test_single_chunk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
